wilkinson_port_power_monitor: RTL and testbench

- Digital stage directly downstream of the Wilkinson divider.
- Consumes paired ADC samples taken at the two divider output ports (port 2 = channel A, port 3 = channel B).
- Over a block of 2^LOG2_N samples, computes the mean power on each channel and flags amplitude imbalance between the arms.
- Results go to the sweep/measurement controller through a valid/ready handshake.

---
 rtl/wilkinson_port_power_monitor.sv | 140 ++++++++++++++
 tb/tb_wilkinson_port_power_monitor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wilkinson_port_power_monitor.sv
// Mean-power monitor for the two Wilkinson divider output ports: squares and
// accumulates a block of 2^LOG2_N sample pairs, then reports per-port mean power and an arm-imbalance flag.
module wilkinson_port_power_monitor #(
    parameter int DATA_W    = 12,
    parameter int LOG2_N    = 4,
    parameter int IMB_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2*DATA_W-2:0]      pwr_a,
    output logic [2*DATA_W-2:0]      pwr_b,
    output logic                     imb_flag,
    output logic                     busy
);

    localparam int SQ_W  = 2 * DATA_W;
    localparam int ACC_W = SQ_W + LOG2_N;
    localparam int PWR_W = 2 * DATA_W - 1;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PWR_W-1:0]   pwr_a_q, pwr_a_d, pwr_b_q, pwr_b_d;
    logic               imb_q, imb_d;

    logic [SQ_W-1:0]    sq_a, sq_b;
    logic [ACC_W-1:0]   acc_a_sum, acc_b_sum;
    logic [PWR_W-1:0]   mean_a, mean_b;

    // Sign-extend before multiplying so the low SQ_W product bits are exact;
    // the square of the most negative code lands on 2^(SQ_W-2) without wrapping.
    function automatic logic [SQ_W-1:0] square(input logic signed [DATA_W-1:0] x);
        logic signed [SQ_W-1:0] xe;
        logic signed [SQ_W-1:0] p;
        xe = {{DATA_W{x[DATA_W-1]}}, x};
        p  = xe * xe;
        return $unsigned(p);
    endfunction

    function automatic logic imbalanced(input logic [PWR_W-1:0] pa,
                                        input logic [PWR_W-1:0] pb);
        logic [PWR_W-1:0] mx, mn;
        mx = (pa > pb) ? pa : pb;
        mn = (pa > pb) ? pb : pa;
        return (mx - mn) > (mx >> IMB_SHIFT);
    endfunction

    assign sq_a      = square(in_a);
    assign sq_b      = square(in_b);
    assign acc_a_sum = acc_a_q + {{LOG2_N{1'b0}}, sq_a};
    assign acc_b_sum = acc_b_q + {{LOG2_N{1'b0}}, sq_b};
    // Mean includes the pair being accepted this cycle; the shift truncates.
    assign mean_a    = acc_a_sum[LOG2_N +: PWR_W];
    assign mean_b    = acc_b_sum[LOG2_N +: PWR_W];

    always_comb begin
        state_d = state_q;
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        cnt_d   = cnt_q;
        pwr_a_d = pwr_a_q;
        pwr_b_d = pwr_b_q;
        imb_d   = imb_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = ACCUM;
                    acc_a_d = '0;
                    acc_b_d = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    acc_a_d = acc_a_sum;
                    acc_b_d = acc_b_sum;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                        pwr_a_d = mean_a;
                        pwr_b_d = mean_b;
                        imb_d   = imbalanced(mean_a, mean_b);
                    end
                end
            end
            DONE: begin
                if (abort || res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_a_q <= '0;
            acc_b_q <= '0;
            cnt_q   <= '0;
            pwr_a_q <= '0;
            pwr_b_q <= '0;
            imb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            cnt_q   <= cnt_d;
            pwr_a_q <= pwr_a_d;
            pwr_b_q <= pwr_b_d;
            imb_q   <= imb_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign pwr_a     = pwr_a_q;
    assign pwr_b     = pwr_b_q;
    assign imb_flag  = imb_q;

endmodule

// File: tb/tb_wilkinson_port_power_monitor.sv
// Self-checking bench for wilkinson_port_power_monitor: a block-level mean-power
// model checked every cycle, plus hand-computed literal results per scenario.
module tb_wilkinson_port_power_monitor;

    localparam int DATA_W    = 12;
    localparam int LOG2_N    = 4;
    localparam int IMB_SHIFT = 3;
    localparam int N         = 1 << LOG2_N;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start, abort, in_valid, res_ready;
    logic signed [DATA_W-1:0] in_a, in_b;
    logic                     in_ready, res_valid, imb_flag, busy;
    logic [2*DATA_W-2:0]      pwr_a, pwr_b;

    wilkinson_port_power_monitor #(
        .DATA_W(DATA_W), .LOG2_N(LOG2_N), .IMB_SHIFT(IMB_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .pwr_a(pwr_a), .pwr_b(pwr_b), .imb_flag(imb_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = idle, 1 = collecting samples, 2 = result pending
    int     m_phase;
    int     m_cnt;
    longint m_sa, m_sb, m_pa, m_pb;
    logic   m_imb;

    function automatic longint sq(input logic signed [DATA_W-1:0] x);
        longint v;
        v = x;
        return v * v;
    endfunction

    function automatic logic imb_ref(input longint pa, input longint pb);
        longint mx, mn;
        mx = (pa > pb) ? pa : pb;
        mn = (pa > pb) ? pb : pa;
        return (mx - mn) > (mx / (1 << IMB_SHIFT));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_cnt <= 0;
            m_sa <= 0; m_sb <= 0; m_pa <= 0; m_pb <= 0; m_imb <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start && !abort) begin
                    m_phase <= 1; m_cnt <= 0; m_sa <= 0; m_sb <= 0;
                end
                1: if (abort) begin
                    m_phase <= 0;
                end else if (in_valid) begin
                    m_sa  <= m_sa + sq(in_a);
                    m_sb  <= m_sb + sq(in_b);
                    m_cnt <= m_cnt + 1;
                    if (m_cnt + 1 == N) begin
                        m_phase <= 2;
                        m_pa    <= (m_sa + sq(in_a)) / N;
                        m_pb    <= (m_sb + sq(in_b)) / N;
                        m_imb   <= imb_ref((m_sa + sq(in_a)) / N, (m_sb + sq(in_b)) / N);
                    end
                end
                default: if (abort || res_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cyc_in_ready",  in_ready,  m_phase == 1);
        chk("cyc_res_valid", res_valid, m_phase == 2);
        chk("cyc_busy",      busy,      m_phase != 0);
        chk("cyc_pwr_a",     pwr_a,     m_pa);
        chk("cyc_pwr_b",     pwr_b,     m_pb);
        chk("cyc_imb_flag",  imb_flag,  m_imb);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_block();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b,
                        input int n, input bit gaps, input bit rnd, input bit mid_start);
        int sent  = 0;
        int guard = 0;
        while (sent < n && guard < 400) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_a     = rnd ? DATA_W'($urandom_range(0, 4095)) : a;
            in_b     = rnd ? DATA_W'($urandom_range(0, 4095)) : b;
            start    = mid_start && (sent == 5);
            tick();
            if (in_valid) sent++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (sent < n) chk("feed_timeout", sent, n);
    endtask

    task automatic expect_result(input string tag, input longint pa, input longint pb,
                                 input logic imb);
        chk({tag, "_res_valid"}, res_valid, 1);
        chk({tag, "_pwr_a"}, pwr_a, pa);
        chk({tag, "_pwr_b"}, pwr_b, pb);
        chk({tag, "_imb"},   imb_flag, imb);
    endtask

    task automatic release_result(input int hold, input bit start_in_done);
        longint pa0, pb0;
        pa0 = pwr_a;
        pb0 = pwr_b;
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = start_in_done && (i % 3 == 1);
            tick();
            chk("hold_res_valid", res_valid, 1);
            chk("hold_in_ready",  in_ready,  0);
            chk("hold_pwr_a",     pwr_a,     pa0);
            chk("hold_pwr_b",     pwr_b,     pb0);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("release_res_valid", res_valid, 0);
        chk("release_busy",      busy,      0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("reset_busy",  busy, 0);
        chk("reset_ready", in_ready, 0);
        chk("reset_pwr_a", pwr_a, 0);
        chk("reset_imb",   imb_flag, 0);

        // sample offers in IDLE must be refused
        in_valid = 1'b1; in_a = 12'sd5; in_b = 12'sd5;
        repeat (4) begin
            tick();
            chk("idle_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;

        begin_block();
        feed(12'sd100, -12'sd100, N, 1'b0, 1'b0, 1'b0);
        expect_result("balanced", 10000, 10000, 1'b0);
        release_result(0, 1'b0);

        begin_block();
        feed(12'sd100, 12'sd70, N, 1'b0, 1'b0, 1'b1);
        expect_result("imb70", 10000, 4900, 1'b1);
        release_result(10, 1'b1);

        begin_block();
        feed(12'sd100, 12'sd96, N, 1'b1, 1'b0, 1'b0);
        expect_result("imb96", 10000, 9216, 1'b0);
        release_result(2, 1'b0);

        begin_block();
        feed(-12'sd2048, 12'sd2047, N, 1'b0, 1'b0, 1'b0);
        expect_result("fullscale", 4194304, 4190209, 1'b0);
        release_result(0, 1'b0);

        begin_block();
        feed('0, '0, N, 1'b1, 1'b1, 1'b0);
        release_result(1, 1'b0);

        begin_block();
        feed(12'sd100, -12'sd100, N, 1'b1, 1'b0, 1'b0);
        expect_result("gaps", 10000, 10000, 1'b0);
        release_result(0, 1'b0);

        // abort after 7 transfers, with a pending offer in the abort cycle
        begin_block();
        feed(12'sd50, 12'sd50, 7, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; abort = 1'b1;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        chk("abort_busy",  busy, 0);
        chk("abort_pwr_a", pwr_a, 10000);
        chk("abort_pwr_b", pwr_b, 10000);
        repeat (20) begin
            tick();
            chk("abort_no_result", res_valid, 0);
        end

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);

        // abort while a result is pending
        begin_block();
        feed(12'sd20, 12'sd10, N, 1'b0, 1'b0, 1'b0);
        expect_result("pre_abort_done", 400, 100, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done_valid", res_valid, 0);
        chk("abort_done_pwr_a", pwr_a, 400);
        chk("abort_done_imb",   imb_flag, 1);

        // asynchronous reset mid-block
        begin_block();
        feed(12'sd100, 12'sd100, 7, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_busy",  busy, 0);
        chk("areset_ready", in_ready, 0);
        chk("areset_pwr_a", pwr_a, 0);
        chk("areset_pwr_b", pwr_b, 0);
        chk("areset_imb",   imb_flag, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        begin_block();
        feed(-12'sd1, 12'sd1, N, 1'b0, 1'b0, 1'b0);
        expect_result("after_reset", 1, 1, 1'b0);
        release_result(0, 1'b0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
